sram_port_arbiter: RTL and testbench

//  Shares the single off-chip SRAM between two requesters: the CPU memory path (fetch/LDR/STR

---
 rtl/sram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the shared asynchronous SRAM: CPU memory path and host loader port.
// One access at a time, fixed-length read/write cycles, registered strobes, one-cycle ack.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus released, arbitrating between cpu_req and host_req
// RD      | CE/UB/LB/OE low, counting down RD_CYCLES
// WR      | CE/UB/LB/WE low, bus driven, counting down WR_CYCLES
// RECOVER | all strobes high, bus released, ack to the served port
module sram_port_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Drive,
    input  logic [DATA_W-1:0] Mem_Din,

    output logic              busy,
    output logic              grant_host
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD      = 2'd1;
    localparam logic [1:0] S_WR      = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic              any_req;
    logic              pick_host;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // grant_host doubles as the round-robin pointer: it names the port served last
    always_comb begin
        any_req   = cpu_req | host_req;
        pick_host = host_req & (~cpu_req | ~grant_host);
        sel_we    = pick_host ? host_we    : cpu_we;
        sel_addr  = pick_host ? host_addr  : cpu_addr;
        sel_wdata = pick_host ? host_wdata : cpu_wdata;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            grant_host <= 1'b1;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
            Mem_CE     <= 1'b1;
            Mem_UB     <= 1'b1;
            Mem_LB     <= 1'b1;
            Mem_OE     <= 1'b1;
            Mem_WE     <= 1'b1;
            Mem_Drive  <= 1'b0;
            Mem_ADDR   <= '0;
            Mem_Dout   <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_host <= pick_host;
                        Mem_ADDR   <= sel_addr;
                        Mem_Dout   <= sel_wdata;
                        Mem_CE     <= 1'b0;
                        Mem_UB     <= 1'b0;
                        Mem_LB     <= 1'b0;
                        if (sel_we) begin
                            Mem_WE    <= 1'b0;
                            Mem_Drive <= 1'b1;
                            cnt       <= WR_LOAD;
                            state     <= S_WR;
                        end else begin
                            Mem_OE <= 1'b0;
                            cnt    <= RD_LOAD;
                            state  <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == '0) begin
                        Mem_CE <= 1'b1;
                        Mem_UB <= 1'b1;
                        Mem_LB <= 1'b1;
                        Mem_OE <= 1'b1;
                        if (grant_host) begin
                            host_rdata <= Mem_Din;
                            host_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= Mem_Din;
                            cpu_ack   <= 1'b1;
                        end
                        state <= S_RECOVER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR: begin
                    if (cnt == '0) begin
                        Mem_CE    <= 1'b1;
                        Mem_UB    <= 1'b1;
                        Mem_LB    <= 1'b1;
                        Mem_WE    <= 1'b1;
                        Mem_Drive <= 1'b0;
                        if (grant_host) begin
                            host_ack <= 1'b1;
                        end else begin
                            cpu_ack <= 1'b1;
                        end
                        state <= S_RECOVER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RECOVER: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed latency checks plus a per-port scoreboard
// whose expected transactions are checked against the SRAM bus activity at each ack.
module tb_sram_port_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int RDC = 2;
    localparam int WRC = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive;
    logic [AW-1:0] Mem_ADDR;
    logic [DW-1:0] Mem_Dout, Mem_Din;
    logic          busy, grant_host;

    // second instance with a longer read cycle
    logic          r4_cpu_req = 1'b0;
    logic [AW-1:0] r4_cpu_addr = '0;
    logic          r4_cpu_ack, r4_host_ack;
    logic [DW-1:0] r4_cpu_rdata, r4_host_rdata;
    logic          r4_CE, r4_UB, r4_LB, r4_OE, r4_WE, r4_Drive;
    logic [AW-1:0] r4_ADDR;
    logic [DW-1:0] r4_Dout, r4_Din;
    logic          r4_busy, r4_grant_host;

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 20'h00123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    assign Mem_Din = mem_model(Mem_ADDR);
    assign r4_Din  = mem_model(r4_ADDR);

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Drive(Mem_Drive), .Mem_Din(Mem_Din),
        .busy(busy), .grant_host(grant_host)
    );

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(4), .WR_CYCLES(2)) dut_rd4 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(r4_cpu_req), .cpu_we(1'b0), .cpu_addr(r4_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_ack(r4_cpu_ack), .cpu_rdata(r4_cpu_rdata),
        .host_req(1'b0), .host_we(1'b0), .host_addr(20'h00000), .host_wdata(16'h0000),
        .host_ack(r4_host_ack), .host_rdata(r4_host_rdata),
        .Mem_CE(r4_CE), .Mem_UB(r4_UB), .Mem_LB(r4_LB), .Mem_OE(r4_OE), .Mem_WE(r4_WE),
        .Mem_ADDR(r4_ADDR), .Mem_Dout(r4_Dout), .Mem_Drive(r4_Drive), .Mem_Din(r4_Din),
        .busy(r4_busy), .grant_host(r4_grant_host)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xact_t;

    xact_t cpu_q[$];
    xact_t host_q[$];
    int    ack_log[$];

    // bus monitor / scoreboard
    int            rd_cnt, wr_cnt;
    logic [AW-1:0] last_ra, last_wa, prev_addr;
    logic [DW-1:0] last_wd, cpu_last;
    logic          addr_moved, drive_bad, prev_strobe;

    always @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_cnt = 0; wr_cnt = 0;
            addr_moved = 1'b0; drive_bad = 1'b0; prev_strobe = 1'b0;
            cpu_last = '0;
        end else begin
            logic  strobe;
            logic  port;
            xact_t e;
            if (!Mem_OE) begin rd_cnt++; last_ra = Mem_ADDR; end
            if (!Mem_WE) begin
                wr_cnt++; last_wa = Mem_ADDR; last_wd = Mem_Dout;
                if (!Mem_Drive) drive_bad = 1'b1;
            end
            strobe = !Mem_OE || !Mem_WE;
            if (strobe && prev_strobe && Mem_ADDR != prev_addr) addr_moved = 1'b1;
            prev_strobe = strobe;
            prev_addr   = Mem_ADDR;
            if (cpu_ack || host_ack) begin
                port = host_ack;
                chk("ack_single", {31'b0, cpu_ack & host_ack}, 0);
                chk("recover_bus", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive}, 6'b111110);
                chk("addr_stable", {addr_moved, drive_bad}, 0);
                chk("grant_host", grant_host, port);
                if ((port ? host_q.size() : cpu_q.size()) == 0) begin
                    chk("sb_unexpected_ack", 1, 0);
                end else begin
                    e = port ? host_q.pop_front() : cpu_q.pop_front();
                    if (e.we) begin
                        chk("wr_cycles", wr_cnt, WRC);
                        chk("wr_no_oe", rd_cnt, 0);
                        chk("wr_addr", last_wa, e.addr);
                        chk("wr_data", last_wd, e.data);
                    end else begin
                        chk("rd_cycles", rd_cnt, RDC);
                        chk("rd_no_we", wr_cnt, 0);
                        chk("rd_addr", last_ra, e.addr);
                        if (port) chk("host_rdata", host_rdata, mem_model(e.addr));
                        else      chk("cpu_rdata", cpu_rdata, mem_model(e.addr));
                        if (!port) cpu_last = mem_model(e.addr);
                    end
                end
                if (port) chk("cpu_rdata_hold", cpu_rdata, cpu_last);
                ack_log.push_back(int'(port));
                rd_cnt = 0; wr_cnt = 0; addr_moved = 1'b0; drive_bad = 1'b0;
            end
        end
    end

    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic scram);
        xact_t e;
        bit    done = 0;
        e.we = we; e.addr = a; e.data = d;
        cpu_q.push_back(e);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge Clk);
            if (cpu_ack) begin
                done = 1;
                cpu_req = 1'b0;
                @(negedge Clk);
                @(negedge Clk);
            end else if (scram && busy && !grant_host) begin
                cpu_addr  = AW'($urandom);
                cpu_wdata = DW'($urandom);
            end
        end
        if (!done) begin
            chk("cpu_ack_timeout", 0, 1);
            cpu_req = 1'b0;
        end
    endtask

    task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic scram);
        xact_t e;
        bit    done = 0;
        e.we = we; e.addr = a; e.data = d;
        host_q.push_back(e);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge Clk);
            if (host_ack) begin
                done = 1;
                host_req = 1'b0;
                @(negedge Clk);
                @(negedge Clk);
            end else if (scram && busy && grant_host) begin
                host_addr  = AW'($urandom);
                host_wdata = DW'($urandom);
            end
        end
        if (!done) begin
            chk("host_ack_timeout", 0, 1);
            host_req = 1'b0;
        end
    endtask

    initial begin
        int mark;
        xact_t e;

        // reset at an arbitrary point, checked before any clock edge
        #3 Reset = 1'b1;
        #1;
        chk("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Drive}, 6'b111110);
        chk("rst_addr_dout", {Mem_ADDR, Mem_Dout}, 0);
        chk("rst_acks_busy", {cpu_ack, host_ack, busy}, 0);
        chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
        chk("rst_grant_host", grant_host, 1);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // CPU read with cycle-exact timing
        e.we = 1'b0; e.addr = 20'h00123; e.data = '0;
        cpu_q.push_back(e);
        cpu_we = 1'b0; cpu_addr = 20'h00123; cpu_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            if (c <= 2) begin
                chk("t2_strobes", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 4'b0010);
                chk("t2_addr", Mem_ADDR, 20'h00123);
            end else if (c == 3) begin
                chk("t2_ack", {cpu_ack, host_ack, Mem_OE}, 3'b101);
                chk("t2_rdata", cpu_rdata, 16'hBEEF);
                cpu_req = 1'b0;
            end else begin
                chk("t2_idle", {busy, cpu_ack}, 0);
            end
        end

        // host write with cycle-exact timing
        e.we = 1'b1; e.addr = 20'h00456; e.data = 16'h1234;
        host_q.push_back(e);
        host_we = 1'b1; host_addr = 20'h00456; host_wdata = 16'h1234; host_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            if (c <= 2) begin
                chk("t3_strobes", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 4'b0101);
                chk("t3_bus", {Mem_ADDR, Mem_Dout}, {20'h00456, 16'h1234});
            end else if (c == 3) begin
                chk("t3_ack", {host_ack, cpu_ack, Mem_WE, Mem_Drive}, 4'b1010);
                chk("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
                host_req = 1'b0;
            end else begin
                chk("t3_idle", {busy, host_ack}, 0);
            end
        end

        // both ports contending; payload changes after grant must be ignored
        mark = ack_log.size();
        fork
            begin
                cpu_xfer(1'b0, 20'h00010, 16'h0000, 1'b1);
                cpu_xfer(1'b1, 20'h00011, 16'h1111, 1'b1);
            end
            begin
                host_xfer(1'b1, 20'h00020, 16'h2020, 1'b1);
                host_xfer(1'b0, 20'h00021, 16'h0000, 1'b1);
            end
        join
        chk("t4_ack_count", ack_log.size() - mark, 4);
        if (ack_log.size() >= mark + 4)
            chk("t4_order", {ack_log[mark][0], ack_log[mark+1][0], ack_log[mark+2][0],
                             ack_log[mark+3][0]}, 4'b0101);

        // reset during host WR cycle 1 with the CPU also requesting
        cpu_xfer(1'b0, 20'h00777, 16'h0000, 1'b0);
        fork
            host_xfer(1'b1, 20'h00ABC, 16'hCAFE, 1'b0);
            begin
                int k = 0;
                while (Mem_WE && k < 20) begin @(negedge Clk); k++; end
                chk("t5_wr_started", {Mem_WE, Mem_Drive}, 2'b01);
                mark = ack_log.size();
                fork
                    cpu_xfer(1'b0, 20'h00321, 16'h0000, 1'b0);
                    begin
                        #2 Reset = 1'b1;
                        #1;
                        chk("t5_async_strobes", {Mem_CE, Mem_OE, Mem_WE, Mem_Drive}, 4'b1110);
                        chk("t5_no_ack", {cpu_ack, host_ack, busy}, 0);
                        #1 Reset = 1'b0;
                    end
                join
            end
        join
        chk("t5_ack_count", ack_log.size() - mark, 2);
        if (ack_log.size() >= mark + 2)
            chk("t5_cpu_first", {ack_log[mark][0], ack_log[mark+1][0]}, 2'b01);
        chk("sb_drained", cpu_q.size() + host_q.size(), 0);

        // RD_CYCLES=4 instance
        @(negedge Clk);
        r4_cpu_addr = 20'h00055; r4_cpu_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (c <= 4) begin
                chk("t6_oe", {r4_CE, r4_OE, r4_cpu_ack}, 0);
            end else if (c == 5) begin
                chk("t6_ack", {r4_cpu_ack, r4_OE, r4_busy}, 3'b111);
                chk("t6_rdata", r4_cpu_rdata, mem_model(20'h00055));
                r4_cpu_req = 1'b0;
            end else begin
                chk("t6_idle", {r4_busy, r4_cpu_ack}, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
